// File: rtl/mspu_ingress_framer.sv
// Ingress framer: reshapes variable-length 512-bit packets into fixed
// FRAME_BEATS-beat frames. Short packets are zero-padded, long packets are
// truncated, and every frame is followed by DRAIN_CYCLES idle cycles so the
// downstream 32-bit unpacker can empty.
module mspu_ingress_framer #(
    parameter int FRAME_BEATS  = 32,
    parameter int DRAIN_CYCLES = 520
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [511:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    output logic [511:0] out_data,
    output logic         pad_pulse,
    output logic         trunc_pulse,
    output logic [7:0]   err_count
);

    typedef enum logic [2:0] {IDLE, PASS, PAD, DROP, DRAIN} state_t;

    localparam logic [10:0] LAST_BEAT  = 11'(FRAME_BEATS - 1);
    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES);

    state_t       state, state_d;
    logic [10:0]  beat_cnt, beat_cnt_d;
    logic [15:0]  drain_cnt, drain_cnt_d;
    logic         vld_d, sop_d, eop_d, pad_d, trunc_d, err_inc;
    logic [511:0] data_d;
    logic         accept;

    // Ready depends only on the registered state, never on in_valid.
    always_comb begin
        in_ready = (state == IDLE) || (state == PASS) || (state == DROP);
    end

    assign accept = in_valid & in_ready;

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_d     = state;
        beat_cnt_d  = beat_cnt;
        drain_cnt_d = drain_cnt;
        vld_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        pad_d       = 1'b0;
        trunc_d     = 1'b0;
        err_inc     = 1'b0;
        data_d      = out_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_sop) begin
                        err_inc = 1'b1;
                    end else begin
                        vld_d      = 1'b1;
                        sop_d      = 1'b1;
                        data_d     = in_data;
                        beat_cnt_d = 11'd1;
                        if (in_eop) begin
                            state_d = PAD;
                            pad_d   = 1'b1;
                        end else begin
                            state_d = PASS;
                        end
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    vld_d      = 1'b1;
                    data_d     = in_data;
                    beat_cnt_d = beat_cnt + 11'd1;
                    if (in_sop) err_inc = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        eop_d = 1'b1;
                        if (in_eop) begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end else begin
                            state_d = DROP;
                            trunc_d = 1'b1;
                        end
                    end else if (in_eop) begin
                        state_d = PAD;
                        pad_d   = 1'b1;
                    end
                end
            end
            PAD: begin
                vld_d      = 1'b1;
                data_d     = '0;
                beat_cnt_d = beat_cnt + 11'd1;
                if (beat_cnt == LAST_BEAT) begin
                    eop_d       = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DROP: begin
                if (accept && in_eop) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // Entered with DRAIN_CYCLES loaded; leaving on 1 gives exactly
                // DRAIN_CYCLES cycles with in_ready low.
                drain_cnt_d = drain_cnt - 16'd1;
                if (drain_cnt == 16'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            err_count   <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= '0;
            pad_pulse   <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            state       <= state_d;
            beat_cnt    <= beat_cnt_d;
            drain_cnt   <= drain_cnt_d;
            out_valid   <= vld_d;
            out_sop     <= sop_d;
            out_eop     <= eop_d;
            out_data    <= data_d;
            pad_pulse   <= pad_d;
            trunc_pulse <= trunc_d;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mspu_ingress_framer.sv
// Directed bench for mspu_ingress_framer with default parameters
// (32-beat frames, 520 drain cycles).
module tb_mspu_ingress_framer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_sop, in_eop;
    logic [511:0] in_data;
    logic         in_ready, out_valid, out_sop, out_eop;
    logic [511:0] out_data;
    logic         pad_pulse, trunc_pulse;
    logic [7:0]   err_count;

    mspu_ingress_framer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .pad_pulse(pad_pulse), .trunc_pulse(trunc_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Output capture: every emitted beat as {sop, eop, data}.
    logic [513:0] q[$];
    int           n_pad = 0, n_trunc = 0;
    always @(negedge clk) begin
        if (out_valid) q.push_back({out_sop, out_eop, out_data});
        if (pad_pulse) n_pad++;
        if (trunc_pulse) n_trunc++;
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [513:0] act, input logic [513:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] dat(input int tag, input int i);
        logic [511:0] r;
        r = '0;
        r[63:32] = tag;
        r[31:0]  = i;
        return r;
    endfunction

    task automatic idle_in;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    endtask

    // Drives an n-beat packet; with gap=1 a bubble follows every beat.
    task automatic send_pkt(input int n, input int tag, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == n - 1); in_data = dat(tag, i);
            step;
            if (gap) begin
                idle_in;
                step;
                chk("gap_no_valid", 514'(out_valid), 514'(0));
            end
        end
        idle_in;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 5000) begin
            step;
            cnt++;
        end
    endtask

    // Checks the 32 beats captured from index start; the first ndata carry data.
    task automatic chk_frame(input string nm, input int start, input int ndata, input int tag);
        chk({nm, "_beats"}, 514'(q.size() - start), 514'(32));
        if (q.size() >= start + 32)
            for (int i = 0; i < 32; i++)
                chk(nm, q[start + i], {i == 0, i == 31, (i < ndata) ? dat(tag, i) : 512'd0});
    endtask

    task automatic do_reset;
        idle_in;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    typedef struct {
        logic         v, sop, eop;
        logic [511:0] d;
        logic         e_rdy, e_vld, e_sop, e_eop;
        logic [511:0] e_d;
        logic         e_pad, e_trunc;
        logic [7:0]   e_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cnt, start, pad0, tr0;

        //        v  sop eop  data          rdy vld sop eop  e_data       pad trn err
        tbl[0] = '{1'b0,1'b0,1'b0, dat(0,0),   1'b1,1'b0,1'b0,1'b0, dat(0,0),  1'b0,1'b0,8'd0}; // idle
        tbl[1] = '{1'b1,1'b0,1'b0, dat(9,9),   1'b1,1'b0,1'b0,1'b0, dat(0,0),  1'b0,1'b0,8'd1}; // stray
        tbl[2] = '{1'b1,1'b1,1'b0, dat(7,0),   1'b1,1'b1,1'b1,1'b0, dat(7,0),  1'b0,1'b0,8'd1}; // sop
        tbl[3] = '{1'b0,1'b0,1'b0, dat(0,0),   1'b1,1'b0,1'b0,1'b0, dat(0,0),  1'b0,1'b0,8'd1}; // bubble
        tbl[4] = '{1'b1,1'b1,1'b0, dat(7,1),   1'b1,1'b1,1'b0,1'b0, dat(7,1),  1'b0,1'b0,8'd2}; // sop mid
        tbl[5] = '{1'b1,1'b0,1'b1, dat(7,2),   1'b1,1'b1,1'b0,1'b0, dat(7,2),  1'b1,1'b0,8'd2}; // short eop
        tbl[6] = '{1'b1,1'b0,1'b0, dat(5,5),   1'b0,1'b1,1'b0,1'b0, dat(0,0),  1'b0,1'b0,8'd2}; // pad

        // Reset state.
        do_reset;
        chk("rst_ready", 514'(in_ready), 514'(1));
        chk("rst_flags", 514'({out_valid, out_sop, out_eop, pad_pulse, trunc_pulse}), 514'(0));
        chk("rst_err", 514'(err_count), 514'(0));
        chk("rst_data", 514'(out_data), 514'(0));

        // Cycle-by-cycle table.
        start = q.size();
        for (int k = 0; k < 7; k++) begin
            in_valid = tbl[k].v; in_sop = tbl[k].sop; in_eop = tbl[k].eop; in_data = tbl[k].d;
            chk($sformatf("tbl%0d_ready", k), 514'(in_ready), 514'(tbl[k].e_rdy));
            step;
            chk($sformatf("tbl%0d_flags", k),
                514'({out_valid, out_sop, out_eop, pad_pulse, trunc_pulse, err_count}),
                514'({tbl[k].e_vld, tbl[k].e_sop, tbl[k].e_eop, tbl[k].e_pad, tbl[k].e_trunc, tbl[k].e_err}));
            if (tbl[k].e_vld) chk($sformatf("tbl%0d_data", k), 514'(out_data), 514'(tbl[k].e_d));
        end
        idle_in;
        // 3 data beats then 29 zero beats remain in PAD, then the drain.
        wait_ready(cnt);
        chk("tbl_frame_beats", 514'(q.size() - start), 514'(32));
        if (q.size() >= start + 32) begin
            chk("tbl_beat31", q[start + 31], {1'b0, 1'b1, 512'd0});
            chk("tbl_beat2", q[start + 2], {1'b0, 1'b0, dat(7, 2)});
        end

        // Exact 32-beat packet, drain of 520 cycles.
        do_reset;
        start = q.size(); pad0 = n_pad; tr0 = n_trunc;
        send_pkt(32, 1, 1'b0);
        wait_ready(cnt);
        chk("exact_drain", 514'(cnt), 514'(520));
        chk_frame("exact", start, 32, 1);
        chk("exact_pulses", 514'({n_pad - pad0, n_trunc - tr0}), 514'(0));

        // Short packet: 5 data beats, 27 zero beats, then drain.
        start = q.size(); pad0 = n_pad;
        send_pkt(5, 2, 1'b0);
        wait_ready(cnt);
        chk("short_wait", 514'(cnt), 514'(27 + 520));
        chk_frame("short", start, 5, 2);
        chk("short_pad", 514'(n_pad - pad0), 514'(1));
        chk("short_err", 514'(err_count), 514'(0));

        // Long packet: 40 beats, truncated after 32.
        start = q.size(); tr0 = n_trunc;
        send_pkt(40, 3, 1'b0);
        chk("long_ready_after_eop", 514'(in_ready), 514'(0));
        wait_ready(cnt);
        chk("long_drain", 514'(cnt), 514'(520));
        chk_frame("long", start, 32, 3);
        chk("long_trunc", 514'(n_trunc - tr0), 514'(1));

        // Stray sop-less beat in IDLE, then a clean packet.
        start = q.size();
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = dat(8, 8);
        step;
        idle_in;
        chk("stray_no_out", 514'(out_valid), 514'(0));
        chk("stray_err", 514'(err_count), 514'(1));
        send_pkt(32, 4, 1'b0);
        wait_ready(cnt);
        chk_frame("stray_pkt", start, 32, 4);

        // Packet with a bubble after every beat.
        start = q.size();
        send_pkt(32, 5, 1'b1);
        wait_ready(cnt);
        chk_frame("gaps", start, 32, 5);

        // Reset mid-frame after 10 beats, then a fresh packet.
        start = q.size();
        send_pkt(10, 6, 1'b0);
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = dat(6, 10);
        reset = 1'b1;
        step;
        idle_in;
        reset = 1'b0;
        chk("midrst_outs", 514'({out_valid, out_sop, out_eop, pad_pulse, trunc_pulse, err_count}), 514'(0));
        chk("midrst_data", 514'(out_data), 514'(0));
        chk("midrst_ready", 514'(in_ready), 514'(1));
        chk("midrst_beats", 514'(q.size() - start), 514'(10));
        if (q.size() >= start + 10) chk("midrst_no_eop", q[start + 9], {1'b0, 1'b0, dat(6, 9)});
        start = q.size();
        send_pkt(32, 7, 1'b0);
        wait_ready(cnt);
        chk_frame("fresh", start, 32, 7);

        // 300 sop-less beats saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = dat(9, i);
            step;
            if (i == 253) chk("err_254", 514'(err_count), 514'(254));
        end
        idle_in;
        step;
        chk("err_sat", 514'(err_count), 514'(255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
